// File: rtl/hazard_stall_controller.sv
// Hazard sequencer: load-use stall, MULT/DIV occupancy stall, taken-branch flush; perf counters.
// Latency: control outputs are combinational from ID/EX inputs; md_busy and counters are registered.
// Backpressure: a stall freezes PC and IF/ID (we=0) and injects an ID/EX bubble; branch flush overrides any stall.
module hazard_stall_controller #(
    parameter int REG_W  = 5,
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             id_reads_hilo,
    input  logic             id_is_md,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             md_issue,
    input  logic             branch_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int MD_W = $clog2(MD_LAT + 1);
    localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MD_LAT);

    logic [MD_W-1:0]  md_cnt_q,    md_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic md_haz;
    logic stall_active;

    always_comb begin
        load_use = ex_memread && (ex_rd != '0) &&
                   ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
        md_busy  = (md_cnt_q != '0);
        md_haz   = md_busy && (id_reads_hilo || id_is_md);
    end

    // Wrong-path instruction in ID makes any stall moot, so the branch wins.
    always_comb begin
        pc_we        = 1'b1;
        ifid_we      = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        stall_active = 1'b0;
        if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (load_use || md_haz) begin
            pc_we        = 1'b0;
            ifid_we      = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
        end
    end

    // The MULT/DIV in EX is never wrong-path, so issue loads even under a branch flush.
    always_comb begin
        md_cnt_d = md_cnt_q;
        if (md_issue) begin
            md_cnt_d = MD_LOAD;
        end else if (md_cnt_q != '0) begin
            md_cnt_d = md_cnt_q - MD_W'(1);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_active && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (branch_taken && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q    <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            md_cnt_q    <= md_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: stimulus queues per-cycle expectations, a negedge monitor checks them.
module tb_hazard_stall_controller;

    localparam int REG_W  = 5;
    localparam int MD_LAT = 4;
    localparam int CNT_W  = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [REG_W-1:0] id_rs, id_rt, ex_rd;
    logic             id_uses_rt, id_reads_hilo, id_is_md;
    logic             ex_memread, md_issue, branch_taken;
    logic             pc_we, ifid_we, ifid_flush, idex_bubble, md_busy;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_stall_controller #(.REG_W(REG_W), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rt   (id_uses_rt),
        .id_reads_hilo(id_reads_hilo),
        .id_is_md     (id_is_md),
        .ex_memread   (ex_memread),
        .ex_rd        (ex_rd),
        .md_issue     (md_issue),
        .branch_taken (branch_taken),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .md_busy      (md_busy),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        logic [4:0]  ctrl;   // {pc_we, ifid_we, ifid_flush, idex_bubble, md_busy}
        logic [31:0] cnts;   // {stall_cnt, flush_cnt}
    } exp_t;

    exp_t exp_q[$];
    bit   done = 1'b0;
    int   errors = 0;
    int   checks = 0;

    task automatic expect_out(input string name, input logic pw, input logic iw, input logic fl,
                              input logic bb, input logic bz, input logic [15:0] sc, input logic [15:0] fc);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.ctrl = {pw, iw, fl, bb, bz};
        e.cnts = {sc, fc};
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic mr, input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urt, input logic hilo, input logic ismd, input logic iss, input logic br);
        ex_memread    = mr;
        ex_rd         = rd;
        id_rs         = rs;
        id_rt         = rt;
        id_uses_rt    = urt;
        id_reads_hilo = hilo;
        id_is_md      = ismd;
        md_issue      = iss;
        branch_taken  = br;
    endtask

    // Monitor: sole owner of the error/check counters and the summary line.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                checks++;
                if (e.cyc != cyc) begin
                    errors++;
                    $display("FAIL %s: sampled at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
                end
                checks++;
                if ({pc_we, ifid_we, ifid_flush, idex_bubble, md_busy} !== e.ctrl) begin
                    errors++;
                    $display("FAIL %s ctrl{pc_we,ifid_we,flush,bubble,busy}: got %b want %b", e.name,
                             {pc_we, ifid_we, ifid_flush, idex_bubble, md_busy}, e.ctrl);
                end
                checks++;
                if ({stall_cnt, flush_cnt} !== e.cnts) begin
                    errors++;
                    $display("FAIL %s counters: got stall=%h flush=%h want stall=%h flush=%h", e.name,
                             stall_cnt, flush_cnt, e.cnts[31:16], e.cnts[15:0]);
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() != 0) begin
                    errors++;
                    $display("FAIL drain: %0d expectations never checked, required 0", exp_q.size());
                end
                $display("Result: errors=%0d of %0d checks", errors, checks);
                $finish;
            end
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        expect_out("reset", 1, 1, 0, 0, 0, 16'd0, 16'd0);
        step();
        rst_n = 1'b1;
        expect_out("idle", 1, 1, 0, 0, 0, 16'd0, 16'd0);
        step();

        // Load-use on rs: one stall cycle, then the bubble in ID/EX clears it.
        drive(1, 8, 8, 3, 1, 0, 0, 0, 0);
        expect_out("lu_rs_stall", 0, 0, 0, 1, 0, 16'd0, 16'd0);
        step();
        drive(0, 0, 8, 3, 1, 0, 0, 0, 0);
        expect_out("lu_rs_after", 1, 1, 0, 0, 0, 16'd1, 16'd0);
        step();

        // rt match only counts when rt is a source; r0 never hazards.
        drive(1, 6, 2, 6, 0, 0, 0, 0, 0);
        expect_out("lu_rt_unused", 1, 1, 0, 0, 0, 16'd1, 16'd0);
        step();
        drive(1, 6, 2, 6, 1, 0, 0, 0, 0);
        expect_out("lu_rt_used", 0, 0, 0, 1, 0, 16'd1, 16'd0);
        step();
        drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
        expect_out("lu_r0", 1, 1, 0, 0, 0, 16'd2, 16'd0);
        step();

        // MULT issues with MFHI behind it: MD_LAT stall cycles.
        drive(0, 0, 0, 0, 0, 1, 0, 1, 0);
        expect_out("md_issue", 1, 1, 0, 0, 0, 16'd2, 16'd0);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_out("md_stall1", 0, 0, 0, 1, 1, 16'd2, 16'd0);
        step();
        expect_out("md_stall2", 0, 0, 0, 1, 1, 16'd3, 16'd0);
        step();
        expect_out("md_stall3", 0, 0, 0, 1, 1, 16'd4, 16'd0);
        step();
        expect_out("md_stall4", 0, 0, 0, 1, 1, 16'd5, 16'd0);
        step();
        expect_out("md_release", 1, 1, 0, 0, 0, 16'd6, 16'd0);
        step();

        // Branch overrides a live load-use match.
        drive(1, 9, 9, 0, 0, 0, 0, 0, 1);
        expect_out("br_over_lu", 1, 1, 1, 1, 0, 16'd6, 16'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("br_after", 1, 1, 0, 0, 0, 16'd6, 16'd1);
        step();

        // MULT issue coincident with branch still loads the counter.
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
        expect_out("br_md_issue", 1, 1, 1, 1, 0, 16'd6, 16'd1);
        step();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 0);
        expect_out("br_md_busy1", 0, 0, 0, 1, 1, 16'd6, 16'd2);
        step();
        expect_out("br_md_busy2", 0, 0, 0, 1, 1, 16'd7, 16'd2);
        step();

        // Reset in the middle of the MULT/DIV stall, without waiting for a clock edge.
        rst_n = 1'b0;
        expect_out("rst_mid_md", 1, 1, 0, 0, 0, 16'd0, 16'd0);
        step();
        expect_out("rst_held", 1, 1, 0, 0, 0, 16'd0, 16'd0);
        step();
        rst_n = 1'b1;
        expect_out("rst_release", 1, 1, 0, 0, 0, 16'd0, 16'd0);
        step();
        drive(1, 4, 4, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst_lu", 0, 0, 0, 1, 0, 16'd0, 16'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("post_rst_norm", 1, 1, 0, 0, 0, 16'd1, 16'd0);
        step();

        // Hold a stall for 65537 cycles; the counter must stick at all-ones.
        drive(1, 5, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65537; i++) begin
            if (i == 65533) expect_out("sat_near", 0, 0, 0, 1, 0, 16'hFFFE, 16'd0);
            step();
        end
        expect_out("sat_hold", 0, 0, 0, 1, 0, 16'hFFFF, 16'd0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("sat_after", 1, 1, 0, 0, 0, 16'hFFFF, 16'd0);
        step();
        step();
        done = 1'b1;
    end

endmodule
